// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one pipelined
// signed-by-unsigned multiplier among NUM_REQ requesters.
//
// Ports
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake
//   mul_ce/mul_din0/mul_din1/mul_dout : multiplier pipe control and data
//   rsp_valid/rsp_id/rsp_data/rsp_ready : in-order result stream
//   busy : any operation in flight
module mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LATENCY  = 4,
    parameter int A_WIDTH  = 64,
    parameter int B_WIDTH  = 63,
    parameter int P_WIDTH  = 126,
    parameter int ID_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       mul_ce,
    output logic [A_WIDTH-1:0]         mul_din0,
    output logic [B_WIDTH-1:0]         mul_din1,
    input  logic [P_WIDTH-1:0]         mul_dout,
    output logic                       rsp_valid,
    output logic [ID_WIDTH-1:0]        rsp_id,
    output logic [P_WIDTH-1:0]         rsp_data,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    last_grant_d;
    logic [LATENCY-1:0]  tag_vld_q;
    logic [LATENCY-1:0]  tag_vld_d;
    logic [ID_WIDTH-1:0] tag_id_q [LATENCY];
    logic [ID_WIDTH-1:0] tag_id_d [LATENCY];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic                grant_any;
    logic [IDX_W-1:0]    grant_idx;
    logic                consume;
    int                  cand_int;
    logic [IDX_W-1:0]    cand;

    // The final tag stage is the response register; the product itself
    // lives in the external multiplier and is only looked at when valid.
    assign rsp_valid = tag_vld_q[LATENCY-1];
    assign rsp_id    = tag_id_q[LATENCY-1];
    assign rsp_data  = rsp_valid ? mul_dout : '0;
    assign consume   = rsp_valid & rsp_ready;

    // The only stall source is an unaccepted response at the output.
    assign mul_ce    = ~(rsp_valid & ~rsp_ready);
    assign busy      = (cnt_q != '0);

    // Round-robin search starting one past the previous winner.
    // Grants are blocked while reset is held so req_ready stays low.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_int  = 0;
        cand      = '0;
        if (reset && mul_ce) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_int = int'(last_grant_q) + k;
                if (cand_int >= NUM_REQ) begin
                    cand_int = cand_int - NUM_REQ;
                end
                cand = IDX_W'(cand_int);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && grant_idx == IDX_W'(i)) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
                mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_any) begin
            last_grant_d = grant_idx;
        end
    end

    // Tag pipe mirrors the multiplier pipe stage for stage, so it must
    // advance on exactly the same enable.
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        if (mul_ce) begin
            tag_vld_d[0] = grant_any;
            tag_id_d[0]  = ID_WIDTH'(grant_idx);
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
        end
    end

    // Grant and consume in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({grant_any, consume})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            tag_vld_q    <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            tag_vld_q    <= tag_vld_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench for mul_arbiter with a behavioural
// multiplier pipe and an in-order response scoreboard.
module tb_mul_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 4;
    localparam int AW  = 64;
    localparam int BW  = 63;
    localparam int PW  = 126;
    localparam int IW  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic             mul_ce;
    logic [AW-1:0]    mul_din0;
    logic [BW-1:0]    mul_din1;
    logic [PW-1:0]    mul_dout;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [PW-1:0]    rsp_data;
    logic             rsp_ready;
    logic             busy;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [PW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_arbiter #(
        .NUM_REQ(NR), .LATENCY(LAT), .A_WIDTH(AW),
        .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Behavioural multiplier: LAT register stages, enabled by mul_ce.
    logic signed [127:0] ea, eb, ep;
    logic [PW-1:0]       mpipe [LAT];

    always_comb begin
        ea = {{64{mul_din0[AW-1]}}, mul_din0};
        eb = {65'b0, mul_din1};
        ep = ea * eb;
    end

    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= ep[PW-1:0];
            for (int i = 1; i < LAT; i++) begin
                mpipe[i] <= mpipe[i-1];
            end
        end
    end

    assign mul_dout = mpipe[LAT-1];

    function automatic logic [PW-1:0] sx(input longint v);
        return {{(PW-64){v[63]}}, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i,
                          input logic [AW-1:0] a,
                          input logic [BW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    task automatic push(input int id, input logic [PW-1:0] d);
        exp_t t;
        t.id   = IW'(id);
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 50) begin
            step();
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0 || busy) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending busy=%0b, want 0 pending busy=0",
                     nm, exp_q.size(), busy);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted response.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid && rsp_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%h, want none",
                             rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        n_err++;
                        $display("FAIL rsp_order: got id=%0d data=%h, want id=%0d data=%h",
                                 rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] mag;
        logic [127:0] neg;

        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        // Outputs under reset, with every requester asking.
        step();
        req_valid = '1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_ce", mul_ce, 1);
        step();
        reset     = 1'b1;
        req_valid = '0;

        // Single issue: -3 * 5 = -15, response after LAT cycles.
        set_op(0, -3, 5);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        push(0, sx(-15));
        for (int c = 1; c <= LAT; c++) begin
            step();
            if (c == 1) req_valid = '0;
            #1;
            chk("single_lat", rsp_valid, (c == LAT));
        end
        drain("single");

        // Two ops in flight from requesters 1 and 2, then reset.
        step();
        set_op(1, 11, 1);
        set_op(2, 12, 1);
        req_valid = 4'b0110;
        #1;
        chk("midrst_grant1", req_ready, 4'b0010);
        step();
        #1;
        chk("midrst_grant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        #1;
        chk("midrst_busy_pre", busy, 1);
        reset     = 1'b0;
        req_valid = '1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 0);
        for (int i = 0; i < NR; i++) begin
            set_op(i, i + 1, 10);
        end
        step();
        step();
        reset = 1'b1;

        // Fairness: all four held for 8 cycles; first winner is 0.
        for (int g = 0; g < 8; g++) begin
            if (g > 0) step();
            #1;
            chk("fair_grant", req_ready, NR'(1) << (g % NR));
            push(g % NR, sx(10 * ((g % NR) + 1)));
            if (g >= LAT) begin
                chk("fair_rsp_valid", rsp_valid, 1);
                chk("fair_busy_full", busy, 1);
            end
        end
        for (int c = 8; c < 8 + LAT; c++) begin
            step();
            if (c == 8) req_valid = '0;
            #1;
            chk("fair_rsp_stream", rsp_valid, 1);
        end
        step();
        #1;
        chk("fair_rsp_end", rsp_valid, 0);
        drain("fair");

        // Backpressure: three issues, output stalled for 5 cycles.
        step();
        set_op(0, 7, 3);
        set_op(1, -8, 2);
        set_op(2, 100, 100);
        req_valid = 4'b0111;
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        push(0, sx(21));
        step();
        #1;
        chk("bp_grant1", req_ready, 4'b0010);
        push(1, sx(-16));
        step();
        #1;
        chk("bp_grant2", req_ready, 4'b0100);
        push(2, sx(10000));
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (s == 0) req_valid = 4'b0111;
            #1;
            chk("bp_mul_ce", mul_ce, 0);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_rsp_data", rsp_data, sx(21));
        end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        drain("bp");

        // Extremes: -2^63 * (2^63-1) = -(2^126-2^63), kept to 126 bits.
        step();
        set_op(3, 64'h8000_0000_0000_0000, 63'h7FFF_FFFF_FFFF_FFFF);
        req_valid = 4'b1000;
        #1;
        chk("ext_grant", req_ready, 4'b1000);
        mag = (128'd1 << 126) - (128'd1 << 63);
        neg = -mag;
        push(3, neg[PW-1:0]);
        step();
        req_valid = '0;
        drain("ext");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
